// File: rtl/dcs_frame_ctrl.sv
// dcs_frame_ctrl: payload -> serial CRC -> FEC launch -> held result.
// Optional FEC-completion watchdog enabled by `define DCS_CTRL_TIMEOUT_EN.
module dcs_frame_ctrl #(
  parameter int PAYLOAD_BITS = 32,
  parameter int FEC_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        crc_start,
  output logic        crc_d,
  input  logic [15:0] crc_in,
  output logic        fec_start,
  output logic [47:0] fec_in,
  input  logic        fec_done,
  input  logic [95:0] ilv_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] out_data,
  output logic [15:0] out_crc,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRC_INIT,
    S_CRC_SHIFT,
    S_CRC_CAPTURE,
    S_FEC_LAUNCH,
    S_FEC_WAIT,
    S_OUTPUT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] payload_q, payload_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic        crc_start_q, crc_start_d;
  logic        fec_start_q, fec_start_d;
  logic        done_q, done_d;
  logic [47:0] fec_in_q, fec_in_d;
  logic [95:0] out_data_q, out_data_d;
  logic [15:0] out_crc_q, out_crc_d;
  logic        fec_edge;
  logic        wd_expire;

  // Only a fresh rise counts; a level left high by the last frame is stale.
  assign fec_edge = fec_done & ~done_q;

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    fec_in_d    = fec_in_q;
    out_data_d  = out_data_q;
    out_crc_d   = out_crc_q;
    crc_start_d = 1'b0;
    fec_start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && rdy_q) begin
          payload_d   = in_data;
          crc_start_d = 1'b1;
          state_d     = S_CRC_INIT;
        end
      end
      S_CRC_INIT: begin
        cnt_d   = 5'(PAYLOAD_BITS - 1);
        state_d = S_CRC_SHIFT;
      end
      S_CRC_SHIFT: begin
        if (cnt_q == 5'd0) begin
          state_d = S_CRC_CAPTURE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_CRC_CAPTURE: begin
        out_crc_d   = crc_in;
        fec_in_d    = {payload_q, crc_in};
        fec_start_d = 1'b1;
        state_d     = S_FEC_LAUNCH;
      end
      S_FEC_LAUNCH: begin
        done_d  = fec_done;
        state_d = S_FEC_WAIT;
      end
      S_FEC_WAIT: begin
        done_d = fec_done;
        if (fec_edge) begin
          out_data_d = ilv_in;
          state_d    = S_OUTPUT;
        end else if (wd_expire) begin
          state_d = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      payload_q   <= '0;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
      crc_start_q <= 1'b0;
      fec_start_q <= 1'b0;
      done_q      <= 1'b0;
      fec_in_q    <= '0;
      out_data_q  <= '0;
      out_crc_q   <= '0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
      crc_start_q <= crc_start_d;
      fec_start_q <= fec_start_d;
      done_q      <= done_d;
      fec_in_q    <= fec_in_d;
      out_data_q  <= out_data_d;
      out_crc_q   <= out_crc_d;
    end
  end

`ifdef DCS_CTRL_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;

  always_comb begin
    wd_d      = '0;
    wd_expire = (state_q == S_FEC_WAIT) && !fec_edge &&
                (wd_q == 16'(FEC_TIMEOUT - 1));
    if ((state_q == S_FEC_WAIT) && !fec_edge) begin
      wd_d = wd_q + 16'd1;
    end
    err_d = wd_expire | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_cfg;

  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = ^{err_clr, FEC_TIMEOUT[0]};
`endif

  assign in_ready  = rdy_q;
  assign crc_start = crc_start_q;
  assign fec_start = fec_start_q;
  assign crc_d     = (state_q == S_CRC_SHIFT) & payload_q[cnt_q];
  assign fec_in    = fec_in_q;
  assign out_valid = (state_q == S_OUTPUT);
  assign out_data  = out_data_q;
  assign out_crc   = out_crc_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dcs_frame_ctrl.sv
// Bench for dcs_frame_ctrl: vector table, corner sequences, random frames.
// CRC engine and FEC/interleaver are stubbed here.
module tb_dcs_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        crc_start;
  logic        crc_d;
  logic [15:0] crc_in;
  logic        fec_start;
  logic [47:0] fec_in;
  logic        fec_done = 1'b0;
  logic [95:0] ilv_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] out_data;
  logic [15:0] out_crc;
  logic        busy;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [47:0] prev_fec = '0;

  // stub CRC engine: serial CRC-16/CCITT, 32 bits after each start strobe
  logic        force_en = 1'b0;
  logic [15:0] force_val = '0;
  logic [15:0] eng = '0;
  logic [5:0]  eng_n = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (crc_start) begin
      eng   <= 16'hFFFF;
      eng_n <= 6'd32;
    end else if (eng_n != 6'd0) begin
      eng   <= {eng[14:0], 1'b0} ^ ((eng[15] ^ crc_d) ? 16'h1021 : 16'h0);
      eng_n <= eng_n - 6'd1;
    end
  end

  assign crc_in = force_en ? force_val : eng;

  dcs_frame_ctrl #(.PAYLOAD_BITS(32), .FEC_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .crc_start(crc_start), .crc_d(crc_d), .crc_in(crc_in),
    .fec_start(fec_start), .fec_in(fec_in), .fec_done(fec_done),
    .ilv_in(ilv_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_crc(out_crc),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  // byte-wise CRC-16/CCITT-FALSE reference
  function automatic logic [15:0] crc_model(input logic [31:0] p);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 3; k >= 0; k--) begin
      c = c ^ {p[8*k +: 8], 8'h00};
      for (int j = 0; j < 8; j++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 100 && in_ready !== 1'b1; n++) @(negedge clk);
    chk("in_ready_wait", 128'(in_ready), 128'(1));
  endtask

  task automatic frame(input logic [31:0] p, input bit fen,
                       input logic [15:0] fcrc, input int lat,
                       input int stall, input bit stale,
                       input logic [47:0] ef, input logic [15:0] ec);
    logic [95:0] eo;
    eo        = {ef, ~ef};
    force_en  = fen;
    force_val = fcrc;
    fec_done  = stale;
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1;
    in_data  = p;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    chk("crc_start_c1", 128'(crc_start), 128'(1));
    chk("busy_c1", 128'(busy), 128'(1));
    chk("in_ready_c1", 128'(in_ready), 128'(0));
    chk("fec_in_hold_c1", 128'(fec_in), 128'(prev_fec));
    for (int b = 31; b >= 0; b--) begin
      @(negedge clk);
      chk("crc_d", 128'(crc_d), 128'(p[b]));
      chk("crc_start_off", 128'(crc_start), 128'(0));
    end
    @(negedge clk);
    chk("crc_d_c34", 128'(crc_d), 128'(0));
    chk("fec_in_hold_c34", 128'(fec_in), 128'(prev_fec));
    chk("fec_start_c34", 128'(fec_start), 128'(0));
    @(negedge clk);
    chk("fec_start_c35", 128'(fec_start), 128'(1));
    chk("crc_start_c35", 128'(crc_start), 128'(0));
    chk("fec_in", 128'(fec_in), 128'(ef));
    chk("out_crc_c35", 128'(out_crc), 128'(ec));
    prev_fec = ef;
    if (stale) begin
      repeat (3) begin
        @(negedge clk);
        chk("stale_no_valid", 128'(out_valid), 128'(0));
      end
      fec_done = 1'b0;
    end
    repeat (lat + 1) begin
      @(negedge clk);
      chk("wait_no_valid", 128'(out_valid), 128'(0));
      chk("wait_fec_start", 128'(fec_start), 128'(0));
    end
    fec_done = 1'b1;
    ilv_in   = eo;
    @(negedge clk);
    chk("out_valid_rise", 128'(out_valid), 128'(1));
    ilv_in = {$urandom, $urandom, $urandom};
    chk("out_data", 128'(out_data), 128'(eo));
    chk("out_crc", 128'(out_crc), 128'(ec));
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_data", 128'(out_data), 128'(eo));
      chk("stall_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    fec_done  = 1'b0;
    chk("post_valid", 128'(out_valid), 128'(0));
    chk("post_in_ready", 128'(in_ready), 128'(1));
    chk("post_busy", 128'(busy), 128'(0));
  endtask

  typedef struct {
    logic [31:0] p;
    logic [15:0] fcrc;
    int          lat;
    int          stall;
    bit          stale;
    logic [47:0] exp_fec;
    logic [15:0] exp_crc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] rp;
    logic [15:0] rc;
    bit          saw;

    vecs[0] = '{32'h8000_0001, 16'h1D0F, 2, 0, 1'b0,
                48'h8000_0001_1D0F, 16'h1D0F};
    vecs[1] = '{32'hDEAD_BEEF, 16'h1234, 9, 1, 1'b1,
                48'hDEAD_BEEF_1234, 16'h1234};
    vecs[2] = '{32'h1234_5678, 16'hABCD, 0, 20, 1'b0,
                48'h1234_5678_ABCD, 16'hABCD};
    vecs[3] = '{32'h0000_0000, 16'h0000, 1, 0, 1'b0,
                48'h0000_0000_0000, 16'h0000};
    vecs[4] = '{32'hFFFF_FFFF, 16'hFFFF, 1, 0, 1'b0,
                48'hFFFF_FFFF_FFFF, 16'hFFFF};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_outs", 128'({crc_start, crc_d, fec_start, out_valid, busy,
                          timeout_err}), 128'(0));
    chk("rst_fec_in", 128'(fec_in), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_crc", 128'(out_crc), 128'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 128'(in_ready), 128'(1));
    chk("rel_busy", 128'(busy), 128'(0));

    // reset in the middle of the CRC shift
    in_valid = 1'b1;
    in_data  = 32'hCAFE_F00D;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_pre", 128'(busy), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_crc_d", 128'(crc_d), 128'(0));
    chk("mid_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      fec_done = i[2];
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    fec_done = 1'b0;
    chk("mid_no_out_valid", 128'(saw), 128'(0));
    chk("mid_idle", 128'({busy, in_ready}), 128'(2'b01));
    prev_fec = '0;

    // table vectors; entries 3 and 4 run back to back
    for (int v = 0; v < 5; v++)
      frame(vecs[v].p, 1'b1, vecs[v].fcrc, vecs[v].lat, vecs[v].stall,
            vecs[v].stale, vecs[v].exp_fec, vecs[v].exp_crc);

    // random frames through the serial CRC stub
    for (int r = 0; r < 8; r++) begin
      rp = $urandom;
      rc = crc_model(rp);
      frame(rp, 1'b0, 16'h0, int'($urandom_range(0, 6)),
            int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            {rp, rc}, rc);
    end

    // FEC never completes
    force_en = 1'b0;
    fec_done = 1'b0;
    rp = 32'h0F0F_3C3C;
    wait_ready();
    in_valid = 1'b1;
    in_data  = rp;
    @(negedge clk);
    in_valid = 1'b0;
    prev_fec = {rp, crc_model(rp)};
`ifdef DCS_CTRL_TIMEOUT_EN
    repeat (50) @(negedge clk);
    chk("wd_pre_err", 128'(timeout_err), 128'(0));
    chk("wd_pre_busy", 128'(busy), 128'(1));
    @(negedge clk);
    chk("wd_err", 128'(timeout_err), 128'(1));
    chk("wd_idle", 128'({busy, in_ready, out_valid}), 128'(3'b010));
    repeat (3) @(negedge clk);
    chk("wd_sticky", 128'(timeout_err), 128'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("wd_clr", 128'(timeout_err), 128'(0));
`else
    repeat (60) @(negedge clk);
    chk("nowd_busy", 128'(busy), 128'(1));
    chk("nowd_no_valid", 128'(out_valid), 128'(0));
    chk("nowd_err", 128'(timeout_err), 128'(0));
    fec_done = 1'b1;
    ilv_in   = {prev_fec, ~prev_fec};
    @(negedge clk);
    chk("nowd_late_valid", 128'(out_valid), 128'(1));
    chk("nowd_late_data", 128'(out_data), 128'({prev_fec, ~prev_fec}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    fec_done  = 1'b0;
    chk("nowd_idle", 128'(in_ready), 128'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
